// File: rtl/uart_bus_bridge_pkg.sv
// uart_bus_bridge shared definitions:
// command/reply codes and frame FSM states.
package uart_bus_bridge_pkg;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP
  } state_t;

endpackage

// File: rtl/uart_bridge_phy.sv
// uart_bridge_phy: rx synchronizer, rx byte engine
// and tx byte engine for the bus bridge.
module uart_bridge_phy #(
  parameter int DIV = 104
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ser_rx,
  output logic       ser_tx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       tx_ready
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  // sync[1] is the synchronized line, sync[2] its previous value
  logic [2:0]    sync;
  logic          rx_act;
  logic [3:0]    rx_bit;
  logic [CW-1:0] rx_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync     <= 3'b111;
      rx_act   <= 1'b0;
      rx_bit   <= 4'd0;
      rx_cnt   <= '0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      sync     <= {sync[1:0], ser_rx};
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_act) begin
        if (sync[2] && !sync[1]) begin
          rx_act <= 1'b1;
          rx_bit <= 4'd0;
          rx_cnt <= '0;
        end
      end else if (rx_bit == 4'd0) begin
        if (rx_cnt == HALF) begin
          rx_cnt <= '0;
          if (sync[1]) rx_act <= 1'b0;
          else         rx_bit <= 4'd1;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end else if (rx_cnt == LAST) begin
        rx_cnt <= '0;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd9) begin
          rx_act   <= 1'b0;
          rx_valid <= sync[1];
          rx_ferr  <= !sync[1];
        end else begin
          rx_data <= {sync[1], rx_data[7:1]};
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  logic [8:0]    tx_sh;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;
  logic          tx_busy;

  // a new byte may be loaded in the last cycle of a stop bit
  assign tx_ready = !tx_busy || (tx_cnt == LAST && tx_bit == 4'd9);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ser_tx  <= 1'b1;
      tx_busy <= 1'b0;
      tx_sh   <= 9'h000;
      tx_bit  <= 4'd0;
      tx_cnt  <= '0;
    end else if (tx_load && tx_ready) begin
      ser_tx  <= 1'b0;
      tx_busy <= 1'b1;
      tx_sh   <= {1'b1, tx_data};
      tx_bit  <= 4'd0;
      tx_cnt  <= '0;
    end else if (tx_busy) begin
      if (tx_cnt == LAST) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          ser_tx  <= 1'b1;
        end else begin
          ser_tx <= tx_sh[0];
          tx_sh  <= {1'b1, tx_sh[8:1]};
          tx_bit <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: UART framed debug initiator
// driving the picorv32 native memory interface.
module uart_bus_bridge
  import uart_bus_bridge_pkg::*;
#(
  parameter int DIV     = 104,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, state_n;
  logic          is_wr;
  logic [1:0]    idx;
  logic [TW-1:0] tcnt;
  logic [31:0]   addr_q, wdata_q, rdata_q;

  logic [7:0]    rx_data, tx_data;
  logic          rx_valid, rx_ferr, tx_load, tx_ready;

  uart_bridge_phy #(.DIV(DIV)) u_phy (
    .clk      (clk),
    .resetn   (resetn),
    .ser_rx   (ser_rx),
    .ser_tx   (ser_tx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .tx_load  (tx_load),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always_comb begin
    state_n = state;
    tx_load = 1'b0;
    tx_data = NAK;
    unique case (state)
      IDLE: if (rx_valid) begin
        if (rx_data == CMD_W || rx_data == CMD_R) state_n = ADDR;
        else tx_load = 1'b1;
      end
      ADDR, DATA: begin
        // a byte arriving on the expiry cycle wins over the timeout
        if (rx_ferr || (!rx_valid && tcnt == TW'(TIMEOUT)))
          state_n = IDLE;
        else if (rx_valid && idx == 2'd3)
          state_n = (state == ADDR && is_wr) ? DATA : BUS;
      end
      BUS: if (mem_ready) begin
        state_n = RESP;
        tx_load = 1'b1;
        tx_data = is_wr ? ACK : mem_rdata[7:0];
      end
      RESP: if (tx_ready) begin
        if (idx != 2'd0) begin
          tx_load = 1'b1;
          tx_data = rdata_q[{idx, 3'b000} +: 8];
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      is_wr   <= 1'b0;
      idx     <= 2'd0;
      tcnt    <= '0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          idx  <= 2'd0;
          tcnt <= '0;
          if (rx_valid) is_wr <= (rx_data == CMD_W);
        end
        ADDR, DATA: begin
          if (rx_valid) begin
            tcnt <= '0;
            idx  <= idx + 2'd1;
            if (state == ADDR) addr_q[{idx, 3'b000} +: 8] <= rx_data;
            else               wdata_q[{idx, 3'b000} +: 8] <= rx_data;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        BUS: if (mem_ready) begin
          rdata_q <= mem_rdata;
          idx     <= is_wr ? 2'd0 : 2'd1;
        end
        RESP: if (tx_ready && idx != 2'd0) idx <= idx + 2'd1;
        default: ;
      endcase
    end
  end

  assign mem_valid = (state == BUS);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = (state == BUS && is_wr) ? 4'hF : 4'h0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: directed frame vectors plus
// timeout, framing, reset and discard sequences.
module tb_uart_bus_bridge;

  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ser_rx = 1'b1;
  logic        ser_tx;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        busy;

  always #5 clk = ~clk;

  uart_bus_bridge #(.DIV(DIV), .TIMEOUT(400)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ser_rx    (ser_rx),
    .ser_tx    (ser_tx),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [16];
  bit mem_init = 1'b0;
  int lat = 0;
  bit hold_low = 1'b0;
  int lcnt = 0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h12345678;
      mem_init <= 1'b1;
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
      lcnt <= 0;
    end else if (mem_ready || !mem_valid || hold_low) begin
      mem_ready <= 1'b0;
      lcnt <= 0;
    end else if (lcnt >= lat) begin
      mem_ready <= 1'b1;
      lcnt <= 0;
      mem_rdata <= mem[mem_addr[5:2]];
      if (mem_wstrb == 4'hF) mem[mem_addr[5:2]] <= mem_wdata;
    end else begin
      lcnt <= lcnt + 1;
    end
  end

  logic        prev_v = 1'b0;
  int          n_bus = 0;
  int          valid_cyc = 0;
  int          rdy_cyc = 0;
  int          unstable = 0;
  int          tx_low_cnt = 0;
  logic [31:0] cap_a = 32'h0;
  logic [31:0] cap_d = 32'h0;
  logic [3:0]  cap_s = 4'h0;

  always @(negedge clk) begin
    if (mem_valid && !prev_v) begin
      n_bus <= n_bus + 1;
      valid_cyc <= cyc;
      cap_a <= mem_addr;
      cap_d <= mem_wdata;
      cap_s <= mem_wstrb;
    end else if (mem_valid && (mem_addr !== cap_a ||
               mem_wdata !== cap_d || mem_wstrb !== cap_s)) begin
      unstable <= unstable + 1;
    end
    if (mem_ready) rdy_cyc <= cyc;
    if (!ser_tx) tx_low_cnt <= tx_low_cnt + 1;
    prev_v <= mem_valid;
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    ser_rx = 1'b0;
    last_start = cyc;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    ser_rx = stop;
    repeat (DIV) @(negedge clk);
    ser_rx = 1'b1;
  endtask

  task automatic get_byte(output logic [7:0] b, output int st);
    int n;
    n = 0;
    b = 8'h00;
    st = -1;
    while (ser_tx !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (ser_tx !== 1'b0) begin
      chk("reply_wait", {31'h0, ser_tx}, 32'h0);
      return;
    end
    st = cyc;
    repeat (DIV / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      b[i] = ser_tx;
    end
    repeat (DIV) @(negedge clk);
    chk("reply_stop", {31'h0, ser_tx}, 32'h1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", {31'h0, busy}, 32'h0);
  endtask

  typedef struct {
    int          n;
    logic [71:0] tx;
    int          lat;
    bit          bus;
    bit          wr;
    logic [31:0] addr;
    int          nrep;
    logic [31:0] rep;
  } vec_t;

  vec_t v[6];

  task automatic run_vec(input int id, input vec_t x);
    int nb0, st, st0, prev, d;
    logic [7:0] b;
    nb0 = n_bus;
    st0 = 0;
    prev = 0;
    lat = x.lat;
    for (int j = 0; j < x.n; j++) send_byte(x.tx[j*8 +: 8], 1'b1);
    for (int k = 0; k < x.nrep; k++) begin
      get_byte(b, st);
      chk($sformatf("v%0d_rep%0d", id, k), {24'h0, b},
          {24'h0, x.rep[k*8 +: 8]});
      if (k == 0) st0 = st;
      else chk($sformatf("v%0d_gap%0d", id, k), st - prev, 32'd80);
      prev = st;
    end
    wait_idle();
    chk($sformatf("v%0d_nbus", id), n_bus - nb0, {31'h0, x.bus});
    if (x.bus) begin
      chk($sformatf("v%0d_addr", id), cap_a, x.addr);
      chk($sformatf("v%0d_wstrb", id), {28'h0, cap_s},
          x.wr ? 32'hF : 32'h0);
      if (x.wr) chk($sformatf("v%0d_wdata", id), cap_d, x.tx[71:40]);
      d = valid_cyc - last_start;
      chk($sformatf("v%0d_vtime(%0d)", id, d),
          {31'h0, (d >= 78 && d <= 82)}, 32'h1);
      d = st0 - rdy_cyc;
      chk($sformatf("v%0d_rlat(%0d)", id, d),
          {31'h0, (d >= 1 && d <= 2)}, 32'h1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb0, lc, st;
    logic [7:0] b;

    v[0] = '{5, {32'h0, 32'h00000013, 8'h52}, 2, 1'b1, 1'b0,
             32'h10, 4, 32'h12345678};
    v[1] = '{9, {32'hDEADBEEF, 32'h00000010, 8'h57}, 3, 1'b1, 1'b1,
             32'h10, 1, 32'h06};
    v[2] = '{1, {64'h0, 8'h41}, 0, 1'b0, 1'b0,
             32'h0, 1, 32'h15};
    v[3] = '{5, {32'h0, 32'h00000011, 8'h52}, 0, 1'b1, 1'b0,
             32'h10, 4, 32'hDEADBEEF};
    v[4] = '{9, {32'h04030201, 32'h00000024, 8'h57}, 1, 1'b1, 1'b1,
             32'h24, 1, 32'h06};
    v[5] = '{5, {32'h0, 32'h00000027, 8'h52}, 2, 1'b1, 1'b0,
             32'h24, 4, 32'h04030201};

    repeat (3) @(negedge clk);
    chk("rst_ser_tx", {31'h0, ser_tx}, 32'h1);
    chk("rst_valid", {31'h0, mem_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i, v[i]);

    // inter-byte timeout inside ADDR
    lc = tx_low_cnt;
    nb0 = n_bus;
    send_byte(8'h57, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (380) @(negedge clk);
    chk("to_busy_before", {31'h0, busy}, 32'h1);
    repeat (30) @(negedge clk);
    chk("to_busy_after", {31'h0, busy}, 32'h0);
    chk("to_nbus", n_bus - nb0, 32'h0);
    chk("to_noreply", tx_low_cnt - lc, 32'h0);
    run_vec(6, v[5]);

    // framing error mid-frame
    lc = tx_low_cnt;
    nb0 = n_bus;
    send_byte(8'h57, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (50) @(negedge clk);
    chk("fe_busy", {31'h0, busy}, 32'h0);
    chk("fe_nbus", n_bus - nb0, 32'h0);
    chk("fe_noreply", tx_low_cnt - lc, 32'h0);

    // reset while the bus request is outstanding
    hold_low = 1'b1;
    send_byte(8'h57, 1'b1);
    send_byte(8'h30, 1'b1);
    repeat (3) send_byte(8'h00, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h11, 1'b1);
    repeat (5) @(negedge clk);
    chk("rb_valid_pre", {31'h0, mem_valid}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("rb_valid", {31'h0, mem_valid}, 32'h0);
    chk("rb_ser_tx", {31'h0, ser_tx}, 32'h1);
    chk("rb_busy", {31'h0, busy}, 32'h0);
    chk("rb_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("rb_addr", mem_addr, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    hold_low = 1'b0;
    repeat (5) @(negedge clk);
    run_vec(7, v[3]);

    // bytes arriving during RESP are dropped
    lat = 1;
    for (int j = 0; j < 5; j++) send_byte(v[5].tx[j*8 +: 8], 1'b1);
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          get_byte(b, st);
          chk($sformatf("dr_rep%0d", k), {24'h0, b},
              {24'h0, v[5].rep[k*8 +: 8]});
        end
      end
      begin
        repeat (30) @(negedge clk);
        send_byte(8'h41, 1'b1);
        send_byte(8'h52, 1'b1);
      end
    join
    repeat (10) @(negedge clk);
    chk("dr_busy", {31'h0, busy}, 32'h0);
    lc = tx_low_cnt;
    repeat (200) @(negedge clk);
    chk("dr_noreply", tx_low_cnt - lc, 32'h0);
    chk("dr_busy_late", {31'h0, busy}, 32'h0);

    chk("bus_stable", unstable, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
